spi_frame_tx: RTL and testbench
===============================

Name: spi_frame_tx

Overview:
- SPI master transmitter; the driving end of the 48-bit signal-data link into the FPGA's SPI receiver.
- Accepts one 48-bit frame (six 8-bit signal bytes, byte 0 in bits 47:40) via valid/ready.
- Serialises the frame MSB-first in SPI mode 0 (CPOL=0, CPHA=0) on a divided sck.
- Used as the bench/loopback source for the receiver, and as the FPGA-side driver for chained boards.

Parameters:
- FRAME_BITS, 48, bits per frame; must be ≥2.
- CLK_DIV, 4, clk cycles per sck half-period; must be ≥1.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high reset.
- frame_data, input, FRAME_BITS, frame to send; sampled only at accept.
- frame_valid, input, 1, frame_data is valid.
- frame_ready, output, 1, block can accept a frame (high only in IDLE).
- sck, output, 1, SPI clock; idles low.
- sdo, output, 1, serial data; drives the receiver's sdi.
- cs_n, output, 1, active-low frame select; see Optional Feature.
- busy, output, 1, a frame is in progress.
- done, output, 1, one-cycle pulse when a frame completes.

Behaviour:
- Reset values: state=IDLE, sck=0, sdo=0, cs_n=1, busy=0, done=0, frame_ready=1, shift register=0, counters=0.
- Interface timing: all outputs are registered; no combinational path from any input to any output.
- Accept: occurs at a clk edge with frame_valid&&frame_ready. frame_data loads into the shift register and a bit counter loads FRAME_BITS.
- States:
  - IDLE: frame_ready=1, busy=0, sck=0. On accept, go to LOW (or SETUP when CS is enabled).
  - LOW: sck=0; sdo=shreg[MSB]. After CLK_DIV cycles, go to HIGH.
  - HIGH: sck=1; sdo is held. After CLK_DIV cycles:
    - Decrement the bit counter and shift shreg left by one (zero fill).
    - If the counter was 1, go to DONE (or HOLD when CS is enabled); otherwise go to LOW.
  - DONE: sck=0, done=1 for exactly one cycle, frame_ready=0. Then go to IDLE.
- Data timing: sdo changes only while sck is low, at least CLK_DIV cycles before each rising edge. The receiver samples on the rising edge.
- Latency, CS disabled, accept at edge 0:
  - First sck rise at cycle CLK_DIV+1.
  - Exactly FRAME_BITS rising edges per frame.
  - done high in cycle 2·CLK_DIV·FRAME_BITS+1.
  - frame_ready high one cycle later.
  - CLK_DIV=4: done in cycle 385.
- Busy: busy=1 in every non-IDLE state.
- frame_valid while busy is ignored; the block never queues a frame.
- Back-to-back: with frame_valid held high, the next accept occurs in the first IDLE cycle after DONE. This gives a 1-cycle gap with sck low.
- CLK_DIV=1: sck toggles every clk; no special case.
- Changes on frame_data after accept have no effect.
- Reset mid-frame:
  - Immediate return to reset values; no done pulse.
  - The receiver holds a partial shift. This is acceptable: its register is a plain 48-bit shift, so the next complete frame fully overwrites it.
- Counter widths: $clog2(FRAME_BITS+1) and $clog2(CLK_DIV+1). The half-period counter resets to 0 on every state change.

Optional Feature:
- Macro SPI_TX_CS_EN.
- Defined:
  - Adds states SETUP (after accept) and HOLD (after the last HIGH), each CLK_DIV cycles with sck=0.
  - cs_n=0 from SETUP entry through HOLD exit; cs_n=1 in DONE and IDLE.
  - Latency becomes done in cycle 2·CLK_DIV·(FRAME_BITS+1)+1.
- Undefined:
  - cs_n is tied to 1.
  - No SETUP/HOLD states; timing exactly as in Behaviour.

Decomposition:
- Package spi_pkg:
  - SPI_FRAME_BITS=48, SIG_BYTES=6, SIG_WIDTH=8.
  - typedef enum logic [2:0] spi_tx_state_t {IDLE, SETUP, LOW, HIGH, HOLD, DONE}.
  - typedef logic [SPI_FRAME_BITS-1:0] spi_frame_t.
- Sub-module spi_half_period_timer:
  - Counts CLK_DIV cycles; emits a one-cycle tick on the last cycle.
  - Cleared on state change.
  - Reused by any future SPI master.

Test Plan:
- Reset: assert reset with no clk edge -> sck=0, sdo=0, cs_n=1, frame_ready=1, busy=0, done=0.
- Single frame, CLK_DIV=2, data 48'hA55A_0102_03FF:
  - Exactly 48 sck rises; bits sampled on rises equal A55A010203FF MSB-first.
  - done in cycle 193 only.
  - Looped into the FPGA SPI receiver: sd0..sd5 = A5,5A,01,02,03,FF.
- Back-to-back, frame_valid held, frames 48'h1 then 48'hFFFF_FFFF_FFFF:
  - Second accept in the cycle after done.
  - Receiver ends with FFFFFFFFFFFF.
- Valid while busy: change frame_data and pulse frame_valid at bit 10 -> ignored, first frame unchanged, only one done.
- Reset mid-frame at the 20th sck rise:
  - Outputs return to reset values immediately; no done.
  - A following frame 48'h123456789ABC is received intact.
- SPI_TX_CS_EN defined, CLK_DIV=3:
  - cs_n falls in the cycle after accept.
  - First sck rise in cycle 7 (3 SETUP + 3 LOW).
  - cs_n rises with done in cycle 295.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI signal-data link (48-bit frames of six 8-bit bytes).
package spi_pkg;

   localparam int SPI_FRAME_BITS = 48;
   localparam int SIG_BYTES      = 6;
   localparam int SIG_WIDTH      = 8;

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} spi_tx_state_t;

   typedef logic [SPI_FRAME_BITS-1:0] spi_frame_t;

endpackage

// File: rtl/spi_frame_tx_timer.sv
// Half-period timer for SPI masters: counts CLK_DIV cycles while enabled and ticks on the last one.
module spi_half_period_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) cnt_d = '0;
      else            cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 master transmitter: one FRAME_BITS frame per valid/ready handshake, MSB first.
// Define SPI_TX_CS_EN to add cs_n framing with SETUP/HOLD half-periods around the data bits.
module spi_frame_tx
   import spi_pkg::*;
#(
   parameter int FRAME_BITS = 48,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FRAME_BITS-1:0] frame_data,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic                  sck,
   output logic                  sdo,
   output logic                  cs_n,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = $clog2(FRAME_BITS + 1);

   spi_tx_state_t         state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bitcnt_q, bitcnt_d;
   logic                  sck_q, sck_d, sdo_q, sdo_d, cs_n_q, cs_n_d;
   logic                  busy_q, busy_d, done_q, done_d, ready_q, ready_d;
   logic                  tick, tmr_en, tmr_clr;

   assign tmr_en  = state_q inside {SETUP, LOW, HIGH, HOLD};
   assign tmr_clr = (state_d != state_q);

   spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk  (clk),
      .rst  (reset),
      .en   (tmr_en),
      .clr  (tmr_clr),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         IDLE: if (frame_valid) begin
            shreg_d  = frame_data;
            bitcnt_d = BW'(FRAME_BITS);
`ifdef SPI_TX_CS_EN
            state_d  = SETUP;
`else
            state_d  = LOW;
`endif
         end
         SETUP: if (tick) state_d = LOW;
         LOW:   if (tick) state_d = HIGH;
         HIGH: if (tick) begin
            bitcnt_d = bitcnt_q - BW'(1);
            shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
`ifdef SPI_TX_CS_EN
            state_d  = (bitcnt_q == BW'(1)) ? HOLD : LOW;
`else
            state_d  = (bitcnt_q == BW'(1)) ? DONE : LOW;
`endif
         end
         HOLD:    if (tick) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so every pin changes on the same edge as the state.
   always_comb begin
      sck_d   = (state_d == HIGH);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
      sdo_d   = 1'b0;
      if (state_d inside {SETUP, LOW})      sdo_d = shreg_d[FRAME_BITS-1];
      else if (state_d inside {HIGH, HOLD}) sdo_d = sdo_q;
`ifdef SPI_TX_CS_EN
      cs_n_d  = !(state_d inside {SETUP, LOW, HIGH, HOLD});
`else
      cs_n_d  = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         sck_q    <= 1'b0;
         sdo_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         sck_q    <= sck_d;
         sdo_q    <= sdo_d;
         cs_n_q   <= cs_n_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign frame_ready = ready_q;
   assign sck         = sck_q;
   assign sdo         = sdo_q;
   assign cs_n        = cs_n_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: stimulus pushes accepted frames, a negedge monitor acts as the
// SPI receiver and checks data, edge counts and handshake timing against a cycle-count model.
module tb_spi_frame_tx;

   localparam int FB = 48;
`ifdef SPI_TX_CS_EN
   localparam int CS = 1;
   localparam int CD = 3;
`else
   localparam int CS = 0;
   localparam int CD = 2;
`endif
   localparam int L = 2 * CD * (FB + CS);   // accept edge to done edge
   localparam int R = CD * (1 + CS);        // accept edge to first sck rise

   logic          clk = 1'b0, reset = 1'b0, frame_valid = 1'b0;
   logic [FB-1:0] frame_data = '0;
   logic          frame_ready, sck, sdo, cs_n, busy, done;

   spi_frame_tx #(.FRAME_BITS(FB), .CLK_DIV(CD)) dut (
      .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .sck(sck), .sdo(sdo), .cs_n(cs_n), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errs = 0, checks = 0;
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         if (errs < 30) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   typedef struct {
      logic [FB-1:0] data;
      int            a;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state: everything derives from the accept edge number.
   int            free_edge = 0, a_cur = -1000000, acc_cnt = 0;
   int            rises = 0, first_rise = 0, last_chg = 0, stab_err = 0;
   logic          prev_sck = 1'b0, prev_sdo = 1'b0, model_ready, exp_cs;
   logic [FB-1:0] rx = '0;
   exp_t          e;

   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
         free_edge = 0; a_cur = -1000000; rises = 0; stab_err = 0;
         prev_sck = 1'b0; prev_sdo = 1'b0;
      end else begin
         model_ready = (cyc >= free_edge);
         check("ready", frame_ready, model_ready);
         check("busy", busy, !model_ready);
         check("done_time", done, (cyc == a_cur + L));
         exp_cs = (CS == 1) ? !(cyc >= a_cur && cyc < a_cur + L) : 1'b1;
         check("cs_n", cs_n, exp_cs);
         if (sck && !prev_sck) begin
            rises++;
            rx = {rx[FB-2:0], sdo};
            if (rises == 1) first_rise = cyc;
            if (cyc - last_chg < CD) stab_err++;
         end
         if (sck && sdo != prev_sdo) stab_err++;
         if (sdo != prev_sdo) last_chg = cyc;
         if (done) begin
            if (sb_q.size() == 0) check("spurious_done", 1, 0);
            else begin
               e = sb_q.pop_front();
               check("rx_data", rx, e.data);
               check("rise_count", rises, FB);
               check("first_rise", first_rise, e.a + R);
               check("sdo_timing", stab_err, 0);
            end
         end
         if (frame_valid && model_ready) begin
            sb_q.push_back('{frame_data, cyc + 1});
            a_cur = cyc + 1;
            free_edge = cyc + 2 + L;
            rises = 0; stab_err = 0;
            acc_cnt++;
         end
         prev_sck = sck; prev_sdo = sdo;
      end
   end

   task automatic send(input logic [FB-1:0] d, input bit keep);
      int n0, k;
      @(posedge clk); #1;
      frame_data = d; frame_valid = 1'b1;
      n0 = acc_cnt; k = 0;
      while (acc_cnt == n0 && k < 4 * L) begin @(posedge clk); k++; end
      if (acc_cnt == n0) check("accept_timeout", 0, 1);
      #1;
      if (!keep) frame_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb_q.size() != 0 && k < 4 * L) begin @(posedge clk); k++; end
      if (sb_q.size() != 0) check("done_timeout", sb_q.size(), 0);
      @(negedge clk); @(negedge clk);
   endtask

   task automatic wait_rises(input int n);
      int k = 0;
      while (rises < n && k < 4 * L) begin @(negedge clk); #1; k++; end
      if (rises < n) check("rise_timeout", rises, n);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sck"}, sck, 0);
      check({tag, "_sdo"}, sdo, 0);
      check({tag, "_cs_n"}, cs_n, 1);
      check({tag, "_ready"}, frame_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   logic [63:0] r;

   initial begin
      #1 reset = 1'b1;
      #1 check_reset_vals("rst0");
      @(negedge clk); @(negedge clk); #1 reset = 1'b0;

      send(48'hA55A_0102_03FF, 0);
      wait_idle();

      send(48'h1, 1);
      send(48'hFFFF_FFFF_FFFF, 0);
      wait_idle();
      check("rx_final_ones", rx, 48'hFFFF_FFFF_FFFF);

      send(48'h0123_4567_89AB, 0);
      wait_rises(10);
      r = {$urandom(), $urandom()};
      frame_data = r[FB-1:0]; frame_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1 frame_valid = 1'b0;
      wait_idle();

      send(48'hDEAD_BEEF_CAFE, 0);
      wait_rises(20);
      reset = 1'b1;
      #1 check_reset_vals("rst_mid");
      @(negedge clk); @(negedge clk); #1 reset = 1'b0;
      send(48'h1234_5678_9ABC, 0);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         r = {$urandom(), $urandom()};
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(r[FB-1:0], (i != 7) && ($urandom_range(0, 1) == 1));
      end
      wait_idle();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
